// File: rtl/otter_pkg.sv
// ----------------------------------------------------------------------------
// otter_pkg -- shared definitions for the OTTER pipeline.
//
// Provides the datapath width, ALU function opcodes, operand-select
// encodings, the x0 register address, the ID/EX holding-register state
// type and a helper that decides whether a writeback source matches a
// source register.
// ----------------------------------------------------------------------------
package otter_pkg;

    localparam int XLEN = 32;

    // ALU function opcodes ({funct7[5], funct3} style encoding)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // Operand source selects
    localparam logic SRCA_RS1 = 1'b0;
    localparam logic SRCA_PC  = 1'b1;
    localparam logic SRCB_RS2 = 1'b0;
    localparam logic SRCB_IMM = 1'b1;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    // A later stage supplies rs when it writes the same register,
    // except x0 which is hard-wired to zero and never forwarded.
    function automatic logic rf_match(input logic       we,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs);
        return we && (rd == rs) && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux -- per-operand forwarding select.
//
// Ports:
//   rs_addr / rs_data          source register address and register-file data
//   mem_rd_addr/_rf_we/_result MEM-stage writeback source (highest priority)
//   wb_rd_addr/_rf_we/_result  WB-stage writeback source
//   rs_resolved                mem match ? mem_result : wb match ? wb_result : rs_data
//   rs_match                   either later stage matches rs (used for hazards
//                              when forwarding is compiled out)
// ----------------------------------------------------------------------------
module fwd_mux
    import otter_pkg::*;
#(
    parameter int XLEN = otter_pkg::XLEN
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_rf_we,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_rf_we,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] rs_resolved,
    output logic            rs_match
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = rf_match(mem_rf_we, mem_rd_addr, rs_addr);
    assign wb_hit  = rf_match(wb_rf_we, wb_rd_addr, rs_addr);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        rs_resolved = rs_data;
        if (mem_hit) begin
            rs_resolved = mem_result;
        end else if (wb_hit) begin
            rs_resolved = wb_result;
        end
    end

    assign rs_match = mem_hit || wb_hit;

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage -- one-entry ID/EX pipeline register with operand selection,
// forwarding and load-use style hazard detection.
//
// Build option: define ID_EX_FORWARD_EN to forward MEM/WB results into the
// operands. Without it, operands come straight from the register file and
// any MEM/WB match against a used source stalls instead.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   in_valid / in_ready            decode-to-stage handshake
//   in_rs1_addr..in_pc             decoded operands
//   in_srcA, in_srcB               operand selects (rs1/pc, rs2/imm)
//   in_alu_fun, in_rd_addr, in_rf_we  control fields carried to EX
//   mem_*, wb_*                    forwarding sources
//   flush                          drop held and incoming instruction
//   ex_valid / ex_ready            stage-to-ALU handshake
//   alu_a, alu_b, alu_fun          registered ALU inputs
//   ex_rd_addr, ex_rf_we           registered destination info
//   stall_cnt                      saturating count of hazard-stall cycles
// ----------------------------------------------------------------------------
module id_ex_stage
    import otter_pkg::*;
#(
    parameter int XLEN = otter_pkg::XLEN
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_srcA,
    input  logic            in_srcB,
    input  logic [3:0]      in_alu_fun,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_rf_we,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_rf_we,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_rf_we,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_fun,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_rf_we,
    output logic [15:0]     stall_cnt
);

    stage_state_t    state_reg;
    stage_state_t    state_next;
    logic [XLEN-1:0] alu_a_reg;
    logic [XLEN-1:0] alu_b_reg;
    logic [3:0]      alu_fun_reg;
    logic [4:0]      ex_rd_addr_reg;
    logic            ex_rf_we_reg;
    logic [15:0]     stall_cnt_reg;

    // Operand index 0 = rs1, 1 = rs2
    logic [4:0]      rs_addr     [2];
    logic [XLEN-1:0] rs_data     [2];
    logic [XLEN-1:0] rs_fwd_data [2];
    logic [XLEN-1:0] rs_resolved [2];
    logic [1:0]      rs_match;
    logic [1:0]      rs_used;

    logic ex_hazard;
    logic src_hazard;
    logic hazard;
    logic capture;
    logic drain;

    assign rs_addr[0] = in_rs1_addr;
    assign rs_addr[1] = in_rs2_addr;
    assign rs_data[0] = in_rs1_data;
    assign rs_data[1] = in_rs2_data;
    assign rs_used[0] = (in_srcA == SRCA_RS1);
    assign rs_used[1] = (in_srcB == SRCB_RS2);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            fwd_mux #(.XLEN(XLEN)) u_fwd_mux (
                .rs_addr     (rs_addr[gi]),
                .rs_data     (rs_data[gi]),
                .mem_rd_addr (mem_rd_addr),
                .mem_rf_we   (mem_rf_we),
                .mem_result  (mem_result),
                .wb_rd_addr  (wb_rd_addr),
                .wb_rf_we    (wb_rf_we),
                .wb_result   (wb_result),
                .rs_resolved (rs_fwd_data[gi]),
                .rs_match    (rs_match[gi])
            );
`ifdef ID_EX_FORWARD_EN
            assign rs_resolved[gi] = rs_fwd_data[gi];
`else
            assign rs_resolved[gi] = rs_data[gi];
`endif
        end
    endgenerate

    // The held instruction's result is not yet visible to MEM/WB, so a
    // dependent instruction must wait until it leaves this stage.
    assign ex_hazard = in_valid && (state_reg == ST_FULL) && ex_rf_we_reg &&
                       (ex_rd_addr_reg != REG_X0) &&
                       ((rs_used[0] && (ex_rd_addr_reg == in_rs1_addr)) ||
                        (rs_used[1] && (ex_rd_addr_reg == in_rs2_addr)));

`ifdef ID_EX_FORWARD_EN
    assign src_hazard = 1'b0;
`else
    // No bypass paths: wait until MEM/WB have written the register file.
    assign src_hazard = in_valid && |(rs_match & rs_used);
`endif

    assign hazard   = ex_hazard || src_hazard;
    assign ex_valid = (state_reg == ST_FULL);
    assign in_ready = (!ex_valid || ex_ready) && !hazard && !flush && !RST;
    assign capture  = in_valid && in_ready;
    assign drain    = ex_valid && ex_ready;

    // Next-state: flush beats capture, capture beats drain.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else if (capture) begin
            state_next = ST_FULL;
        end else if (drain) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Payload only loads on capture, which keeps it stable under back-pressure.
    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_fun_reg    <= ALU_ADD;
            ex_rd_addr_reg <= REG_X0;
            ex_rf_we_reg   <= 1'b0;
        end else if (capture) begin
            alu_a_reg      <= (in_srcA == SRCA_PC)  ? in_pc  : rs_resolved[0];
            alu_b_reg      <= (in_srcB == SRCB_IMM) ? in_imm : rs_resolved[1];
            alu_fun_reg    <= in_alu_fun;
            ex_rd_addr_reg <= in_rd_addr;
            ex_rf_we_reg   <= in_rf_we;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_reg <= '0;
        end else if (in_valid && hazard && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_fun    = alu_fun_reg;
    assign ex_rd_addr = ex_rd_addr_reg;
    assign ex_rf_we   = ex_rf_we_reg;
    assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage -- directed scoreboard bench for id_ex_stage.
// The driver pushes the hand-computed expected entry for every instruction
// it expects to be captured; a monitor pops and compares on every
// ex_valid && ex_ready transfer.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fun;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        in_srcA, in_srcB;
    logic [3:0]  in_alu_fun;
    logic [4:0]  in_rd_addr;
    logic        in_rf_we;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_rf_we, wb_rf_we;
    logic [31:0] mem_result, wb_result;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [4:0]  ex_rd_addr;
    logic        ex_rf_we;
    logic [15:0] stall_cnt;

    int   checks = 0;
    int   errors = 0;
    int   n_push = 0;
    int   n_drop = 0;
    int   n_pop  = 0;
    int   exp_stall = 0;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    id_ex_stage #(.XLEN(32)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_srcA(in_srcA), .in_srcB(in_srcB),
        .in_alu_fun(in_alu_fun), .in_rd_addr(in_rd_addr), .in_rf_we(in_rf_we),
        .mem_rd_addr(mem_rd_addr), .mem_rf_we(mem_rf_we), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_rf_we(wb_rf_we), .wb_result(wb_result),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .ex_rd_addr(ex_rd_addr), .ex_rf_we(ex_rf_we),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        in_rs1_addr = '0; in_rs2_addr = '0;
        in_rs1_data = '0; in_rs2_data = '0;
        in_imm      = '0; in_pc       = '0;
        in_srcA     = 1'b0; in_srcB   = 1'b0;
        in_alu_fun  = '0; in_rd_addr  = '0; in_rf_we = 1'b0;
        mem_rd_addr = '0; mem_rf_we   = 1'b0; mem_result = '0;
        wb_rd_addr  = '0; wb_rf_we    = 1'b0; wb_result  = '0;
        flush       = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r1a, input logic [4:0] r2a,
                         input logic [31:0] r1d, input logic [31:0] r2d,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic sa, input logic sb, input logic [3:0] fun,
                         input logic [4:0] rd, input logic we);
        in_valid    = 1'b1;
        in_rs1_addr = r1a; in_rs2_addr = r2a;
        in_rs1_data = r1d; in_rs2_data = r2d;
        in_imm      = imm; in_pc       = pc;
        in_srcA     = sa;  in_srcB     = sb;
        in_alu_fun  = fun; in_rd_addr  = rd; in_rf_we = we;
    endtask

    task automatic expect_entry(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] fun, input logic [4:0] rd, input logic we);
        exp_t e;
        e.a = a; e.b = b; e.fun = fun; e.rd = rd; e.we = we;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic drop_all();
        n_drop += exp_q.size();
        exp_q.delete();
    endtask

    // Monitor: one comparison per transfer out of the stage.
    always @(negedge CLK) begin
        if (!RST && ex_valid && ex_ready) begin
            exp_t e;
            exp_t got;
            got = {alu_a, alu_b, alu_fun, ex_rd_addr, ex_rf_we};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got a=0x%0h b=0x%0h fun=%b rd=%0d we=%0b expected no transfer",
                         alu_a, alu_b, alu_fun, ex_rd_addr, ex_rf_we);
            end else begin
                e = exp_q.pop_front();
                n_pop++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb_entry: got a=0x%0h b=0x%0h fun=%b rd=%0d we=%0b expected a=0x%0h b=0x%0h fun=%b rd=%0d we=%0b",
                             alu_a, alu_b, alu_fun, ex_rd_addr, ex_rf_we, e.a, e.b, e.fun, e.rd, e.we);
                end else begin
                    $display("ok   sb_entry: a=0x%0h b=0x%0h fun=%b rd=%0d we=%0b",
                             alu_a, alu_b, alu_fun, ex_rd_addr, ex_rf_we);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, with an instruction offered that must not be accepted
        idle();
        RST      = 1'b1;
        ex_ready = 1'b1;
        issue(5'd1, 5'd2, 32'h9, 32'h9, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 5'd1, 1'b1);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        step();
        chk("rst_ex_valid",   {31'd0, ex_valid}, 32'd0);
        chk("rst_alu_a",      alu_a, 32'd0);
        chk("rst_alu_b",      alu_b, 32'd0);
        chk("rst_alu_fun",    {28'd0, alu_fun}, 32'd0);
        chk("rst_ex_rd_addr", {27'd0, ex_rd_addr}, 32'd0);
        chk("rst_ex_rf_we",   {31'd0, ex_rf_we}, 32'd0);
        chk("rst_stall_cnt",  {16'd0, stall_cnt}, 32'd0);
        idle();
        RST = 1'b0;
        step();

        // Basic capture: rs1/rs2 data straight through, 1-cycle latency
        issue(5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 5'd1, 1'b1);
        expect_entry(32'd5, 32'd7, 4'b0000, 5'd1, 1'b1);
        step();
        idle();
        chk("basic_ex_valid", {31'd0, ex_valid}, 32'd1);
        step();
        chk("basic_drained", {31'd0, ex_valid}, 32'd0);

        // pc / imm selects
        issue(5'd0, 5'd0, 32'h0, 32'h0, 32'h20, 32'h100, 1'b1, 1'b1, 4'b1000, 5'd2, 1'b1);
        expect_entry(32'h100, 32'h20, 4'b1000, 5'd2, 1'b1);
        step();
        idle();
        step();

`ifdef ID_EX_FORWARD_EN
        // MEM beats WB on rs1
        issue(5'd3, 5'd0, 32'h11, 32'h0, 32'h9, 32'h0, 1'b0, 1'b1, 4'b0000, 5'd7, 1'b1);
        mem_rd_addr = 5'd3; mem_rf_we = 1'b1; mem_result = 32'hAA;
        wb_rd_addr  = 5'd3; wb_rf_we  = 1'b1; wb_result  = 32'hBB;
        expect_entry(32'hAA, 32'h9, 4'b0000, 5'd7, 1'b1);
        step();
        idle();
        step();
        // WB-only match on rs2 (MEM address matches but not writing)
        issue(5'd0, 5'd5, 32'h22, 32'h33, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 5'd7, 1'b1);
        mem_rd_addr = 5'd5; mem_rf_we = 1'b0; mem_result = 32'hDD;
        wb_rd_addr  = 5'd5; wb_rf_we  = 1'b1; wb_result  = 32'hCC;
        expect_entry(32'h22, 32'hCC, 4'b0000, 5'd7, 1'b1);
        step();
        idle();
        step();
`else
        // WB match on used rs1 stalls until the WB entry clears
        issue(5'd3, 5'd0, 32'h11, 32'h0, 32'h9, 32'h0, 1'b0, 1'b1, 4'b0000, 5'd7, 1'b1);
        wb_rd_addr = 5'd3; wb_rf_we = 1'b1; wb_result = 32'hBB;
        #1;
        chk("wb_hazard_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        step();
        exp_stall += 2;
        chk("wb_hazard_stall_cnt", {16'd0, stall_cnt}, exp_stall);
        chk("wb_hazard_no_capture", {31'd0, ex_valid}, 32'd0);
        wb_rf_we = 1'b0;
        #1;
        chk("wb_clear_in_ready", {31'd0, in_ready}, 32'd1);
        expect_entry(32'h11, 32'h9, 4'b0000, 5'd7, 1'b1);
        step();
        idle();
        step();
`endif

        // x0 is never forwarded nor treated as a dependency
        issue(5'd0, 5'd0, 32'h44, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 5'd8, 1'b1);
        mem_rd_addr = 5'd0; mem_rf_we = 1'b1; mem_result = 32'hEE;
        wb_rd_addr  = 5'd0; wb_rf_we  = 1'b1; wb_result  = 32'hFF;
        #1;
        chk("x0_in_ready", {31'd0, in_ready}, 32'd1);
        expect_entry(32'h44, 32'h55, 4'b0000, 5'd8, 1'b1);
        step();
        idle();
        step();

        // Hazard against the held instruction (rd=x4)
        ex_ready = 1'b0;
        issue(5'd0, 5'd0, 32'h0, 32'h0, 32'h4, 32'h40, 1'b1, 1'b1, 4'b0000, 5'd4, 1'b1);
        expect_entry(32'h40, 32'h4, 4'b0000, 5'd4, 1'b1);
        step();
        idle();
        chk("hz_full", {31'd0, ex_valid}, 32'd1);
        issue(5'd0, 5'd4, 32'h0, 32'h66, 32'h0, 32'h80, 1'b1, 1'b0, 4'b0000, 5'd9, 1'b1);
        #1;
        chk("hz_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_stall++;
            chk("hz_stall_cnt", {16'd0, stall_cnt}, exp_stall);
        end
        in_srcB = 1'b1;
        step();
        chk("hz_srcb_imm_no_stall", {16'd0, stall_cnt}, exp_stall);

        // Back-pressure: outputs hold for 3 cycles
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_alu_a", alu_a, 32'h40);
            chk("bp_alu_b", alu_b, 32'h4);
            chk("bp_rd", {27'd0, ex_rd_addr}, 32'd4);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        // Drain and capture in the same cycle
        ex_ready = 1'b1;
        issue(5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 32'h200, 1'b1, 1'b1, 4'b1001, 5'd10, 1'b0);
        #1;
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        expect_entry(32'h200, 32'h8, 4'b1001, 5'd10, 1'b0);
        step();
        idle();
        chk("b2b_ex_valid", {31'd0, ex_valid}, 32'd1);
        step();
        chk("b2b_drained", {31'd0, ex_valid}, 32'd0);

        // Flush while FULL with a new instruction offered
        ex_ready = 1'b0;
        issue(5'd0, 5'd0, 32'h0, 32'h0, 32'h1, 32'h300, 1'b1, 1'b1, 4'b0000, 5'd11, 1'b1);
        expect_entry(32'h300, 32'h1, 4'b0000, 5'd11, 1'b1);
        step();
        idle();
        issue(5'd0, 5'd0, 32'h0, 32'h0, 32'h2, 32'h400, 1'b1, 1'b1, 4'b0000, 5'd12, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        idle();
        drop_all();
        chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        step();
        chk("flush_no_capture", {31'd0, ex_valid}, 32'd0);

        // Reset in the middle of a stall with stall_cnt = 9
        issue(5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h500, 1'b1, 1'b1, 4'b0000, 5'd6, 1'b1);
        expect_entry(32'h500, 32'h0, 4'b0000, 5'd6, 1'b1);
        step();
        idle();
        issue(5'd6, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4'b0000, 5'd13, 1'b1);
        while (exp_stall < 9) begin
            step();
            exp_stall++;
        end
        chk("mid_stall_cnt", {16'd0, stall_cnt}, 32'd9);
        RST = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        drop_all();
        exp_stall = 0;
        chk("mid_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("mid_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        RST = 1'b0;
        idle();
        ex_ready = 1'b1;
        step();
        step();

        chk("sb_queue_empty", exp_q.size(), 32'd0);
        chk("sb_pop_count", n_pop, n_push - n_drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of operands and results.
REQ-002 SHALL have port CLK  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid in 1 and in_ready out 1, the decode-to-stage handshake.
REQ-005 SHALL have inputs in_rs1_addr 5, in_rs2_addr 5, in_rs1_data XLEN, in_rs2_data XLEN, in_imm XLEN, in_pc XLEN: decoded operands.
REQ-006 SHALL have inputs in_srcA 1 (0=rs1, 1=pc), in_srcB 1 (0=rs2, 1=imm), in_alu_fun 4, in_rd_addr 5, in_rf_we 1.
REQ-007 SHALL have inputs mem_rd_addr 5, mem_rf_we 1, mem_result XLEN, wb_rd_addr 5, wb_rf_we 1, wb_result XLEN: forwarding sources.
REQ-008 SHALL have input flush 1, which discards the held and incoming instruction.
REQ-009 SHALL have ports ex_valid out 1 and ex_ready in 1, the stage-to-ALU handshake.
REQ-010 SHALL have outputs alu_a XLEN, alu_b XLEN, alu_fun 4, ex_rd_addr 5, ex_rf_we 1, feeding the ALU A, B and alu_fun inputs.
REQ-011 SHALL have output stall_cnt 16, a count of hazard-stall cycles.

Function
REQ-012 SHALL hold one entry with two states: EMPTY (ex_valid=0) and FULL (ex_valid=1).
REQ-013 SHALL compute in_ready = (!ex_valid || ex_ready) && !hazard && !flush.
REQ-014 SHALL capture all in_* fields on a rising edge with in_valid && in_ready, and enter FULL; this is 1-cycle latency.
REQ-015 SHALL go FULL->EMPTY on ex_valid && ex_ready with no capture in the same cycle, and stay FULL when a capture coincides with that drain.
REQ-016 SHALL keep all ex outputs stable while ex_valid && !ex_ready.
REQ-017 SHALL resolve rs1 and rs2 at capture time, using priority mem match > wb match > in_rsX_data.
REQ-018 SHALL define a match as rf_we=1, rd_addr == rsX_addr and rd_addr != 0; x0 is never forwarded.
REQ-019 SHALL register alu_a = srcA ? in_pc : rs1_resolved and alu_b = srcB ? in_imm : rs2_resolved.
REQ-020 SHALL assert hazard when in_valid, ex_valid and ex_rf_we are set, ex_rd_addr != 0, and ex_rd_addr equals a used source: rs1 if srcA=0, rs2 if srcB=0.
REQ-021 SHALL, on flush, go to EMPTY next cycle and capture nothing that cycle; flush has priority over capture and drain.
REQ-022 SHALL increment stall_cnt each cycle with in_valid && hazard, saturating at 16'hFFFF without wrap.
REQ-023 SHALL place no ALU arithmetic in this block; it only selects and registers operands.

Reset
REQ-024 SHALL, on RST=1 at a clock edge, set ex_valid=0, alu_a=0, alu_b=0, alu_fun=4'b0000, ex_rd_addr=0, ex_rf_we=0 and stall_cnt=0.
REQ-025 SHALL give RST priority over flush, capture and drain, and drop any held instruction when reset arrives mid-operation.
REQ-026 SHALL hold in_ready=0 in the cycle RST is high.

Configuration
REQ-027 SHALL use macro ID_EX_FORWARD_EN to compile the forwarding logic in or out.
REQ-028 SHALL, with ID_EX_FORWARD_EN defined, forward as in REQ-017.
REQ-029 SHALL, without ID_EX_FORWARD_EN, use in_rsX_data directly and also assert hazard on any mem or wb match (as REQ-018) against a used source.

Structure
REQ-030 SHALL take from the shared package otter_pkg: XLEN, ALU_FUN opcode constants (ADD=0000, SUB=1000, LUI=1001, and so on), SRCA/SRCB encodings, and REG_X0=5'd0.
REQ-031 SHALL contain one sub-module, fwd_mux, one instance per source operand, implementing the REQ-017/018 priority select.

Verification
REQ-032 SHALL cover: RST then in_valid=1, in_rs1_data=5, in_rs2_data=7, srcA=0, srcB=0, fun=0000, ex_ready=1 -> next cycle ex_valid=1, alu_a=5, alu_b=7, alu_fun=0000.
REQ-033 SHALL cover: rs1=x3, mem_rd=x3, mem_we=1, mem_result=0xAA, wb_rd=x3, wb_result=0xBB -> alu_a=0xAA; with rs1=x0 and mem_rd=x0 -> alu_a=in_rs1_data.
REQ-034 SHALL cover: FULL with ex_rd=x4, ex_rf_we=1, new in rs2=x4, srcB=0 -> in_ready=0 and stall_cnt +1 per cycle; srcB=1 -> no stall.
REQ-035 SHALL cover: ex_ready=0 for 3 cycles while FULL -> outputs unchanged and in_ready=0; ex_ready=1 and in_valid=1 in the same cycle -> back-to-back transfer, ex_valid stays 1.
REQ-036 SHALL cover: flush=1 with in_valid=1 while FULL -> next cycle ex_valid=0, no capture; RST mid-stall with stall_cnt=9 -> stall_cnt=0, ex_valid=0.
REQ-037 SHALL cover, with ID_EX_FORWARD_EN undefined: a wb match on rs1 -> hazard asserted and in_ready=0 until the wb entry clears.
